// File: rtl/axi_lite_mem_port_if.sv
// AXI4-lite bus bundle between the core memory port (master) and the memory fabric (slave).
interface axi_lite_mem_port_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddress;
    logic [2:0]        awprot;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddress;
    logic [2:0]        arprot;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddress, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddress, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddress, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddress, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_mem_port.sv
// Core load/store/fetch port: one request becomes one AXI4-lite transaction, with lane alignment,
// strobes, load extension, error mapping and a bus-wait watchdog.
//
//   state        | meaning
//   IDLE         | req_ready=1, waiting for a core request
//   RD_ADDR      | arvalid/rready up, waiting for the ar handshake
//   RD_DATA      | address taken, waiting for rvalid
//   WR_ADDR_DATA | awvalid/wvalid up, each drops on its own handshake
//   WR_RESP      | bready up, waiting for bvalid
//   RESP         | rsp_valid held with rdata/err until rsp_ready
//   HUNG         | watchdog fired; bus outputs frozen until reset
module axi_lite_mem_port #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic                req_instr,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_err,
    axi_lite_mem_port_if.master bus
);
    localparam int STRB_W  = DATA_W / 8;
    localparam int OFF_W   = $clog2(STRB_W);
    localparam int WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int WD_LOAD = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ALIGN   = 2'd1;
    localparam logic [1:0] ERR_BUS     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, RESP, HUNG
    } state_t;

    state_t            state;
    logic [1:0]        lat_size;
    logic              lat_signed;
    logic [OFF_W-1:0]  lat_off;
    logic              aw_done;
    logic              w_done;
    logic              hung;
    logic [WD_W-1:0]   wd;

    logic              misaligned;
    logic [2:0]        size_mask;
    logic [7:0]        strb_base;
    logic              in_wait;
    logic              bus_done;
    logic              wd_fire;
    logic              aw_now;
    logic              w_now;
    logic              r_err;
    logic              b_err;
    logic [DATA_W-1:0] load_data;

    // Shift the addressed lanes down, keep 8<<size bits, then sign- or zero-fill above them.
    function automatic logic [DATA_W-1:0] load_extend(
        input logic [DATA_W-1:0] d,
        input logic [OFF_W-1:0]  off,
        input logic [1:0]        size,
        input logic              sgn
    );
        logic [DATA_W-1:0] s;
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] top;
        logic [6:0]        nb;
        logic              sbit;
        s    = d >> {off, 3'b000};
        nb   = 7'd8 << size;
        mask = (nb >= 7'(DATA_W)) ? {DATA_W{1'b1}} : ((DATA_W'(1) << nb) - DATA_W'(1));
        top  = mask & ~(mask >> 1);
        sbit = |(s & top);
        return (s & mask) | ((sgn && sbit) ? ~mask : {DATA_W{1'b0}});
    endfunction

    always_comb begin
        size_mask  = 3'((4'd1 << req_size) - 4'd1);
        misaligned = ((req_addr[2:0] & size_mask) != 3'd0) || (req_size == 2'd3 && DATA_W == 32);
        case (req_size)
            2'd0:    strb_base = 8'h01;
            2'd1:    strb_base = 8'h03;
            2'd2:    strb_base = 8'h0f;
            default: strb_base = 8'hff;
        endcase
        r_err     = (bus.rresp == 2'b10) || (bus.rresp == 2'b11);
        b_err     = (bus.bresp == 2'b10) || (bus.bresp == 2'b11);
        load_data = load_extend(bus.rdata, lat_off, lat_size, lat_signed);
        aw_now    = aw_done || (bus.awvalid && bus.awready);
        w_now     = w_done || (bus.wvalid && bus.wready);
        in_wait   = (state == RD_ADDR) || (state == RD_DATA) ||
                    (state == WR_ADDR_DATA) || (state == WR_RESP);
        bus_done  = (state == RD_ADDR && bus.arvalid && bus.arready && bus.rvalid) ||
                    (state == RD_DATA && bus.rvalid) ||
                    (state == WR_RESP && bus.bvalid);
        wd_fire   = (TIMEOUT != 0) && in_wait && (wd == '0) && !bus_done;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= ERR_OK;
            bus.awvalid   <= 1'b0;
            bus.awaddress <= '0;
            bus.awprot    <= 3'b000;
            bus.wvalid    <= 1'b0;
            bus.wdata     <= '0;
            bus.wstrb     <= '0;
            bus.bready    <= 1'b0;
            bus.arvalid   <= 1'b0;
            bus.araddress <= '0;
            bus.arprot    <= 3'b000;
            bus.rready    <= 1'b0;
            lat_size      <= 2'd0;
            lat_signed    <= 1'b0;
            lat_off       <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            hung          <= 1'b0;
            wd            <= '0;
        end else begin
            if (in_wait && wd != '0) begin
                wd <= wd - WD_W'(1);
            end

            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        lat_off    <= req_addr[OFF_W-1:0];
                        wd         <= WD_W'(WD_LOAD);
                        if (misaligned) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= ERR_ALIGN;
                            rsp_rdata <= '0;
                            state     <= RESP;
                        end else if (req_write) begin
                            bus.awvalid   <= 1'b1;
                            bus.awaddress <= req_addr;
                            bus.awprot    <= req_instr ? 3'b101 : 3'b000;
                            bus.wvalid    <= 1'b1;
                            bus.wdata     <= req_wdata << {req_addr[OFF_W-1:0], 3'b000};
                            bus.wstrb     <= STRB_W'(strb_base) << req_addr[OFF_W-1:0];
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            state         <= WR_ADDR_DATA;
                        end else begin
                            bus.arvalid   <= 1'b1;
                            bus.araddress <= req_addr;
                            bus.arprot    <= req_instr ? 3'b101 : 3'b000;
                            bus.rready    <= 1'b1;
                            state         <= RD_ADDR;
                        end
                    end
                end

                RD_ADDR: begin
                    if (bus.arvalid && bus.arready) begin
                        bus.arvalid <= 1'b0;
                        if (bus.rvalid) begin
                            bus.rready <= 1'b0;
                            rsp_valid  <= 1'b1;
                            rsp_err    <= r_err ? ERR_BUS : ERR_OK;
                            rsp_rdata  <= r_err ? '0 : load_data;
                            state      <= RESP;
                        end else begin
                            state <= RD_DATA;
                        end
                    end
                end

                RD_DATA: begin
                    if (bus.rvalid) begin
                        bus.rready <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_err    <= r_err ? ERR_BUS : ERR_OK;
                        rsp_rdata  <= r_err ? '0 : load_data;
                        state      <= RESP;
                    end
                end

                WR_ADDR_DATA: begin
                    if (bus.awvalid && bus.awready) begin
                        bus.awvalid <= 1'b0;
                        aw_done     <= 1'b1;
                    end
                    if (bus.wvalid && bus.wready) begin
                        bus.wvalid <= 1'b0;
                        w_done     <= 1'b1;
                    end
                    // bready only rises once both channels are through, so an early bvalid is never taken.
                    if (aw_now && w_now) begin
                        bus.bready <= 1'b1;
                        state      <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (bus.bvalid) begin
                        bus.bready <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_err    <= b_err ? ERR_BUS : ERR_OK;
                        rsp_rdata  <= '0;
                        state      <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (hung) begin
                            state <= HUNG;
                        end else begin
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end

                HUNG: begin
                    req_ready <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            // Watchdog overrides the state move but leaves bus valids alone: AXI forbids withdrawing them.
            if (wd_fire) begin
                rsp_valid <= 1'b1;
                rsp_err   <= ERR_TIMEOUT;
                rsp_rdata <= '0;
                hung      <= 1'b1;
                state     <= RESP;
            end
        end
    end
endmodule
